// File: rtl/wave_draw_scheduler.sv
// Decimates stereo audio into plotted waveform points and sequences the shared
// line drawer: black erase columns first, then the white segment to the new point.
module wave_draw_scheduler #(
  parameter int LOG2_SAMPLES = 12,
  parameter int X_STEP       = 4,
  parameter int SCREEN_W     = 640,
  parameter int SCREEN_H     = 480,
  parameter int Y_CENTER     = 240,
  parameter int SCALE_SHIFT  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        read,
  input  logic [23:0] audio_left,
  input  logic [23:0] audio_right,
  output logic        line_start,
  input  logic        line_done,
  output logic [10:0] x0,
  output logic [10:0] y0,
  output logic [10:0] x1,
  output logic [10:0] y1,
  output logic        line_color,
  output logic        busy,
  output logic        overrun
);

  localparam int AW = 25 + LOG2_SAMPLES;
  localparam int YW = AW + 2;
  localparam logic [10:0] X_LAST = 11'(SCREEN_W - 1);
  localparam logic [10:0] Y_LAST = 11'(SCREEN_H - 1);

  typedef enum logic [2:0] {IDLE, ERASE_REQ, ERASE_WAIT, DRAW_REQ, DRAW_WAIT} state_t;
  state_t state_reg, state_next;

  logic [24:0]             pair_sum;
  logic signed [AW-1:0]    acc_reg, acc_sum, avg, scaled;
  logic signed [YW-1:0]    y_full;
  logic [10:0]             y_point;
  logic [LOG2_SAMPLES-1:0] cnt_reg;
  logic                    point_done, consume;
  logic                    pending_reg, overrun_reg;
  logic [10:0]             pend_y_reg;
  logic [10:0]             x_prev_reg, y_prev_reg, y_new_reg, nx_reg, col_reg, nx_calc;
  logic                    wrap_reg;

  // Window sum includes the read that completes it; the window then restarts empty.
  always_comb begin
    pair_sum = {audio_left[23], audio_left} + {audio_right[23], audio_right};
    acc_sum  = acc_reg + {{(AW-25){pair_sum[24]}}, pair_sum};
    avg      = acc_sum >>> LOG2_SAMPLES;
    scaled   = avg >>> SCALE_SHIFT;
    y_full   = YW'(Y_CENTER) - {{2{scaled[AW-1]}}, scaled};
    if (y_full < 0)
      y_point = '0;
    else if (y_full > YW'(SCREEN_H - 1))
      y_point = Y_LAST;
    else
      y_point = y_full[10:0];
  end

  assign point_done = read && (cnt_reg == '1);
  assign consume    = (state_reg == IDLE) && pending_reg;
  assign nx_calc    = x_prev_reg + 11'(X_STEP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_reg <= '0;
      cnt_reg <= '0;
    end else if (read) begin
      if (point_done) begin
        acc_reg <= '0;
        cnt_reg <= '0;
      end else begin
        acc_reg <= acc_sum;
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  // A point arriving while one is still waiting is dropped, unless the FSM frees the slot this cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_reg <= 1'b0;
      overrun_reg <= 1'b0;
      pend_y_reg  <= '0;
    end else begin
      if (consume)
        pending_reg <= 1'b0;
      if (point_done) begin
        if (pending_reg && !consume) begin
          overrun_reg <= 1'b1;
        end else begin
          pending_reg <= 1'b1;
          pend_y_reg  <= y_point;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    line_start = 1'b0;
    x0         = '0;
    y0         = '0;
    x1         = '0;
    y1         = '0;
    line_color = 1'b0;
    case (state_reg)
      IDLE: if (pending_reg) state_next = ERASE_REQ;
      ERASE_REQ: begin
        line_start = 1'b1;
        x0         = col_reg;
        x1         = col_reg;
        y1         = Y_LAST;
        state_next = ERASE_WAIT;
      end
      ERASE_WAIT: begin
        x0 = col_reg;
        x1 = col_reg;
        y1 = Y_LAST;
        if (line_done) begin
          if (col_reg != nx_reg)
            state_next = ERASE_REQ;
          else
            state_next = wrap_reg ? IDLE : DRAW_REQ;
        end
      end
      DRAW_REQ: begin
        line_start = 1'b1;
        x0         = x_prev_reg;
        y0         = y_prev_reg;
        x1         = nx_reg;
        y1         = y_new_reg;
        line_color = 1'b1;
        state_next = DRAW_WAIT;
      end
      DRAW_WAIT: begin
        x0         = x_prev_reg;
        y0         = y_prev_reg;
        x1         = nx_reg;
        y1         = y_new_reg;
        line_color = 1'b1;
        if (line_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // On wrap nx is forced to 0, so the erase range collapses to column 0 alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_prev_reg <= '0;
      y_prev_reg <= 11'(Y_CENTER);
      y_new_reg  <= '0;
      nx_reg     <= '0;
      col_reg    <= '0;
      wrap_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: if (pending_reg) begin
          y_new_reg <= pend_y_reg;
          if (nx_calc > X_LAST) begin
            wrap_reg <= 1'b1;
            nx_reg   <= '0;
            col_reg  <= '0;
          end else begin
            wrap_reg <= 1'b0;
            nx_reg   <= nx_calc;
            col_reg  <= x_prev_reg + 11'd1;
          end
        end
        ERASE_WAIT: if (line_done) begin
          if (col_reg != nx_reg) begin
            col_reg <= col_reg + 11'd1;
          end else if (wrap_reg) begin
            x_prev_reg <= '0;
            y_prev_reg <= y_new_reg;
          end
        end
        DRAW_WAIT: if (line_done) begin
          x_prev_reg <= nx_reg;
          y_prev_reg <= y_new_reg;
        end
        default: ;
      endcase
    end
  end

  assign busy    = (state_reg != IDLE);
  assign overrun = overrun_reg;

endmodule

// File: tb/tb_wave_draw_scheduler.sv
// Scoreboard bench: a plotting model queues the expected drawer lines and a
// monitor/drawer-emulator compares every line_start against the queue.
module tb_wave_draw_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        read;
  logic [23:0] audio_left, audio_right;
  logic        line_start, line_done;
  logic [10:0] x0, y0, x1, y1;
  logic        line_color, busy, overrun;

  wave_draw_scheduler #(.LOG2_SAMPLES(2), .X_STEP(4)) dut (
    .clk(clk), .reset(reset), .read(read),
    .audio_left(audio_left), .audio_right(audio_right),
    .line_start(line_start), .line_done(line_done),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1),
    .line_color(line_color), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [10:0] x0, y0, x1, y1;
    logic        color;
    logic        last;
  } line_t;

  line_t exp_q[$];
  int    n_vec = 0, n_err = 0;
  int    n_starts = 0, n_col0 = 0;
  int    cd = 0;
  bit    cur_last = 0, chk_start_next = 0, chk_idle_next = 0;
  bit    mon_en = 0, hold_done = 0;
  int    m_xp = 0, m_yp = 240;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int model_y(input longint total);
    longint avg, off, y;
    avg = total >>> 2;
    off = avg >>> 16;
    y = 240 - off;
    if (y < 0) y = 0;
    if (y > 479) y = 479;
    return int'(y);
  endfunction

  task automatic plot(input int y);
    line_t e;
    int nx = m_xp + 4;
    if (nx > 639) begin
      e = '{x0:0, y0:0, x1:0, y1:479, color:0, last:1};
      exp_q.push_back(e);
      m_xp = 0;
      m_yp = y;
    end else begin
      for (int c = m_xp + 1; c <= nx; c++) begin
        e = '{x0:11'(c), y0:0, x1:11'(c), y1:479, color:0, last:0};
        exp_q.push_back(e);
      end
      e = '{x0:11'(m_xp), y0:11'(m_yp), x1:11'(nx), y1:11'(y), color:1, last:1};
      exp_q.push_back(e);
      m_xp = nx;
      m_yp = y;
    end
  endtask

  task automatic wait_drain(input int budget);
    bit ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && cd == 0 && !busy && !chk_idle_next) ok = 1;
    end
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: %0d lines still expected, busy %0b", exp_q.size(), busy);
    end
  endtask

  task automatic do_read(input logic [23:0] l, input logic [23:0] r);
    @(negedge clk);
    read = 1'b1;
    audio_left = l;
    audio_right = r;
    @(posedge clk);
    #1 read = 1'b0;
  endtask

  task automatic send_point(input logic [23:0] lv, input logic [23:0] rv, input bit rnd,
                            input bit plot_it, input bit drain, input bit lat);
    longint total = 0;
    logic [23:0] l, r;
    int k;
    for (int i = 0; i < 4; i++) begin
      l = rnd ? 24'($urandom) : lv;
      r = rnd ? 24'($urandom) : rv;
      total += longint'($signed(l)) + longint'($signed(r));
      if (i == 3) begin
        if (drain) wait_drain(2000);
        if (plot_it) plot(model_y(total));
      end
      if (rnd) repeat ($urandom_range(0, 2)) @(negedge clk);
      do_read(l, r);
    end
    if (lat) begin
      k = 0;
      while (k < 20) begin
        @(negedge clk);
        k++;
        if (line_start) break;
      end
      chk("point_to_start_latency", k, 2);
    end
  endtask

  // Drawer emulator and monitor: answers each line after a random delay.
  initial begin
    line_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        line_done = 1'b0;
        if (chk_start_next) begin
          chk("done_to_start", line_start, 1);
          chk_start_next = 0;
        end
        if (chk_idle_next) begin
          chk("busy_drop", busy, 0);
          chk_idle_next = 0;
        end
        if (line_start) begin
          n_starts++;
          if (x0 == 0 && x1 == 0 && !line_color) n_col0++;
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_line: x0=%0d y0=%0d x1=%0d y1=%0d c=%0b", x0, y0, x1, y1, line_color);
          end else begin
            e = exp_q.pop_front();
            chk("line", {x0, y0, x1, y1, line_color}, {e.x0, e.y0, e.x1, e.y1, e.color});
            cur_last = e.last;
            cd = $urandom_range(1, 4);
          end
        end else if (cd > 0 && !hold_done) begin
          cd--;
          if (cd == 0) begin
            line_done = 1'b1;
            if (cur_last) chk_idle_next = 1;
            else chk_start_next = 1;
          end
        end
      end
    end
  end

  initial begin
    int s;
    reset = 1'b1;
    read = 1'b0;
    audio_left = '0;
    audio_right = '0;
    line_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {line_start, x0, y0, x1, y1, line_color, busy, overrun}, 0);
    reset = 1'b0;
    mon_en = 1;

    send_point(24'h010000, 24'h010000, 0, 1, 1, 1);
    wait_drain(500);
    send_point(24'hF00000, 24'hF00000, 0, 1, 1, 0);
    send_point(24'h7FFFFF, 24'h7FFFFF, 0, 1, 1, 0);
    send_point(24'h800000, 24'h800000, 0, 1, 1, 0);
    wait_drain(500);
    chk("overrun_clear", overrun, 0);

    // Stall the drawer: one point in flight, one pending, one dropped.
    hold_done = 1;
    s = n_starts;
    send_point(24'h000000, 24'h000000, 0, 1, 1, 0);
    for (int i = 0; i < 50 && n_starts == s; i++) @(negedge clk);
    chk("stall_started", n_starts, s + 1);
    send_point(24'h100000, 24'h000000, 0, 1, 0, 0);
    @(negedge clk);
    chk("overrun_before_drop", overrun, 0);
    send_point(24'h300000, 24'h300000, 0, 0, 0, 0);
    @(negedge clk);
    chk("overrun_after_drop", overrun, 1);
    hold_done = 0;
    wait_drain(1000);
    repeat (30) @(negedge clk);
    chk("idle_after_overrun", busy, 0);

    for (int p = 0; p < 160; p++) send_point('0, '0, 1, 1, 1, 0);
    wait_drain(1000);
    chk("wrap_erase_count", n_col0, 1);
    chk("overrun_sticky", overrun, 1);

    // Reset while the drawer is mid-line, then deliver a stale line_done.
    hold_done = 1;
    s = n_starts;
    send_point(24'h050000, 24'h020000, 0, 1, 0, 0);
    for (int i = 0; i < 50 && n_starts == s; i++) @(negedge clk);
    chk("midline_started", busy, 1);
    mon_en = 0;
    @(negedge clk);
    #2 reset = 1'b1;
    #1 chk("midline_reset_outputs", {line_start, x0, y0, x1, y1, line_color, busy, overrun}, 0);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    cd = 0;
    chk_start_next = 0;
    chk_idle_next = 0;
    hold_done = 0;
    @(negedge clk);
    line_done = 1'b1;
    @(negedge clk);
    line_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("post_reset_quiet", {line_start, busy}, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wave_draw_scheduler.md
Name: wave_draw_scheduler

Overview:
- Sequences the framebuffer line drawer for the scrolling audio-waveform display.
- Decimates the 48 kHz stereo codec stream into one plotted point per 2^LOG2_SAMPLES sample pairs and maps each point to a screen y coordinate.
- Before drawing each new waveform segment, issues vertical black erase lines over the columns the segment will occupy.
- Sits between the audio codec interface (read strobe) and the shared line-drawer engine (start/done handshake).

Parameters:
- LOG2_SAMPLES, 12: log2 of sample pairs averaged per plotted point.
- X_STEP, 4: horizontal pixels advanced per point; range 1..15.
- SCREEN_W, 640: display width in pixels.
- SCREEN_H, 480: display height in pixels.
- Y_CENTER, 240: y coordinate for zero amplitude.
- SCALE_SHIFT, 16: arithmetic right shift applied to the average to get pixel offset.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- read  in  1  one-cycle strobe: audio_left/audio_right are valid this cycle.
- audio_left  in  24  signed two's-complement sample.
- audio_right  in  24  signed two's-complement sample.
- line_start  out  1  one-cycle pulse requesting a line from the drawer.
- line_done  in  1  one-cycle pulse from the drawer when its current line is finished.
- x0, y0, x1, y1  out  11 each  line endpoints.
- line_color  out  1  1 = draw (white), 0 = erase (black).
- busy  out  1  high whenever the FSM is not in IDLE.
- overrun  out  1  sticky flag: a point was dropped; cleared only by reset.

Behaviour:
- Reset: one clock domain (clk); reset is asynchronous and active-high.
  - All outputs are 0, and the FSM is in IDLE.
  - Accumulator and sample counter are 0; pending flag is clear.
  - Previous point is (0, Y_CENTER).
- Accumulation runs independently of the FSM:
  - On each read, sum = sext(L) + sext(R) (25 b signed) is added to the accumulator (25+LOG2_SAMPLES b signed), and the counter increments.
  - When the counter reaches 2^LOG2_SAMPLES:
    - avg = acc >>> LOG2_SAMPLES.
    - y = Y_CENTER − (avg >>> SCALE_SHIFT), computed at full width and clamped to [0, SCREEN_H−1].
    - The accumulator and counter restart with the current read's sample not included; the next read starts the new window.
  - The resulting y is written to the pending register and the pending flag is set.
- Pending/overrun:
  - If pending is already set when a new point completes, the new point is dropped, pending keeps the old value, and overrun is set.
  - If the FSM consumes pending in the same cycle a new point completes, the new point is stored and overrun is not set.
- FSM states: IDLE, ERASE_REQ, ERASE_WAIT, DRAW_REQ, DRAW_WAIT.
- IDLE: when pending is set, consume it (clear the flag, latch y_new).
  - nx = x_prev + X_STEP.
  - If nx > SCREEN_W−1: wrap. Set x_new = 0 and erase column 0 only; no segment is drawn; the previous point becomes (0, y_new).
  - Otherwise: erase columns x_prev+1 .. nx, then draw the segment.
  - Set the erase column counter to the first erase column, then go to ERASE_REQ.
- ERASE_REQ:
  - Drive x0 = x1 = column, y0 = 0, y1 = SCREEN_H−1, line_color = 0.
  - Pulse line_start for exactly one cycle, then go to ERASE_WAIT.
- ERASE_WAIT: hold all endpoints and colour stable until line_done.
  - On line_done, if the column equals the last erase column, go to DRAW_REQ, or to IDLE after a wrap.
  - Otherwise increment the column and go to ERASE_REQ.
- DRAW_REQ:
  - Drive (x0, y0) = (x_prev, y_prev), (x1, y1) = (nx, y_new), line_color = 1.
  - Pulse line_start, then go to DRAW_WAIT.
- DRAW_WAIT: on line_done, set prev = (nx, y_new) and go to IDLE.
- Handshake rules:
  - line_start is never asserted outside the REQ states.
  - line_done is ignored in every state except the WAIT states.
  - Latency from line_done to the next line_start is exactly 1 cycle within a point.
  - Latency from pending set in IDLE to the first line_start is 2 cycles.
- Reset mid-line: the FSM returns to IDLE immediately and line_start drops. A late line_done is ignored.

Test Plan:
- LOG2_SAMPLES=2, X_STEP=4: 4 reads with L=R=24'h010000.
  - Required: erase lines at x = 1, 2, 3, 4, each spanning y 0..479 with colour 0.
  - Then a draw from (0,240) to (4,238) with colour 1.
  - busy drops 1 cycle after the final line_done.
- 4 reads with L=R=24'hF00000 → y_new = 272; segment from (4,238) to (8,272).
- 4 reads with L=R=24'h7FFFFF → y is clamped to 0; L=R=24'h800000 → y is clamped to 479.
- Hold line_done low while 8 more reads arrive:
  - The first completed point sets pending; the second is dropped and overrun = 1.
  - After line_done is returned, exactly one further point is plotted.
- Start with x_prev = 636 and X_STEP = 4:
  - Required: a single erase of column 0, no draw line, and the next point's erase covers columns 1..4.
- Assert reset while in ERASE_WAIT, then pulse line_done after reset is released:
  - Required: all outputs are 0, the FSM stays in IDLE, and no line_start is issued.
